// File: rtl/dmem_dma_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_dma_ctrl
//
// Owns the single-port data memory (one read or one write per cycle) and
// shares it between the CPU load/store port and an internal block copy/fill
// engine. The CPU normally wins arbitration. A starvation counter forces one
// engine cycle after MAXWAIT consecutive lost cycles, so the engine always
// makes progress. A copy needs a read cycle and then a write cycle per byte.
// A fill needs only the write cycle.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   CpuReq/CpuWe        CPU access request and write flag
//   CpuAddr/CpuWData    CPU address and write data
//   CpuGrant            comb, CPU access performed this cycle
//   CpuRData            comb, memory read data passthrough
//   DmaStart            start command, sampled only while the engine is idle
//   DmaFill             1 = fill with DmaPattern, 0 = copy DmaSrc -> DmaDst
//   DmaSrc/DmaDst       copy source and destination base addresses
//   DmaLen              byte count (0 = no-op, completes at once)
//   DmaPattern          fill byte
//   DmaBusy/DmaDone     registered engine status and one-cycle done pulse
//   MemWriteEn/MemAddr/MemWData/MemRData   memory port
// ----------------------------------------------------------------------------
module dmem_dma_ctrl #(
    parameter int W       = 8,
    parameter int A       = 8,
    parameter int MAXWAIT = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         CpuReq,
    input  logic         CpuWe,
    input  logic [A-1:0] CpuAddr,
    input  logic [W-1:0] CpuWData,
    output logic         CpuGrant,
    output logic [W-1:0] CpuRData,
    input  logic         DmaStart,
    input  logic         DmaFill,
    input  logic [A-1:0] DmaSrc,
    input  logic [A-1:0] DmaDst,
    input  logic [A-1:0] DmaLen,
    input  logic [W-1:0] DmaPattern,
    output logic         DmaBusy,
    output logic         DmaDone,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddr,
    output logic [W-1:0] MemWData,
    input  logic [W-1:0] MemRData
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t         state;
    logic [A-1:0]   src;
    logic [A-1:0]   dst;
    logic [A-1:0]   count;
    logic           fill;
    logic [W-1:0]   pattern;
    logic [W-1:0]   hold;
    logic [3:0]     waitcnt;

    logic           wants;
    logic           forced;
    logic           enggrant;

    // Arbitration and memory port steering. The engine is kept off the bus
    // while Reset is high, so a reset arriving mid-transfer cannot slip in
    // one more write. A forced engine cycle denies the CPU even if it is
    // requesting. When nobody is granted, the CPU address and data are
    // passed through with the write enable held low.
    always_comb begin
        wants      = ((state == RD) || (state == WR)) && !Reset;
        forced     = wants && (waitcnt == 4'(MAXWAIT));
        CpuGrant   = CpuReq && !forced;
        enggrant   = forced || (wants && !CpuReq);
        MemWriteEn = 1'b0;
        MemAddr    = CpuAddr;
        MemWData   = CpuWData;
        if (CpuGrant) begin
            MemWriteEn = CpuWe;
        end else if (enggrant) begin
            if (state == WR) begin
                MemAddr    = dst;
                MemWriteEn = 1'b1;
                MemWData   = fill ? pattern : hold;
            end else begin
                MemAddr    = src;
            end
        end
    end

    assign CpuRData = MemRData;

    // Engine sequencer and starvation counter. Losing arbitration leaves
    // every engine register untouched. The counter counts only the cycles
    // the engine wanted the bus and lost, and it saturates at MAXWAIT. The
    // last write checks count==1 because count is decremented on that same
    // edge. Bytes are processed in ascending address order and wrap mod 2**A.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            count   <= '0;
            fill    <= 1'b0;
            pattern <= '0;
            hold    <= '0;
            waitcnt <= '0;
            DmaBusy <= 1'b0;
            DmaDone <= 1'b0;
        end else begin
            if (!wants || enggrant) begin
                waitcnt <= '0;
            end else if (waitcnt != 4'(MAXWAIT)) begin
                waitcnt <= waitcnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (DmaStart) begin
                        if (DmaLen == '0) begin
                            state   <= DONE;
                            DmaDone <= 1'b1;
                        end else begin
                            src     <= DmaSrc;
                            dst     <= DmaDst;
                            count   <= DmaLen;
                            fill    <= DmaFill;
                            pattern <= DmaPattern;
                            state   <= DmaFill ? WR : RD;
                            DmaBusy <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (enggrant) begin
                        hold  <= MemRData;
                        state <= WR;
                    end
                end
                WR: begin
                    if (enggrant) begin
                        src   <= src + 1'b1;
                        dst   <= dst + 1'b1;
                        count <= count - 1'b1;
                        if (count == A'(1)) begin
                            state   <= DONE;
                            DmaBusy <= 1'b0;
                            DmaDone <= 1'b1;
                        end else if (!fill) begin
                            state <= RD;
                        end
                    end
                end
                DONE: begin
                    DmaDone <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dma_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_dma_ctrl
//
// Drives dmem_dma_ctrl against a behavioural 256-byte memory. A reference
// model tracks the expected outcome. It holds pending engine work as a queue
// of byte operations (read source / write destination), a starvation count
// and its own copy of memory. Each cycle it predicts the grant, the memory
// port and the status outputs, and then retires one operation whenever the
// engine should own the bus. A directed sequence comes first, followed by
// randomized traffic.
// ----------------------------------------------------------------------------
module tb_dmem_dma_ctrl;

    localparam int MAXWAIT = 4;

    logic       Clk, Reset;
    logic       CpuReq, CpuWe, CpuGrant;
    logic [7:0] CpuAddr, CpuWData, CpuRData;
    logic       DmaStart, DmaFill, DmaBusy, DmaDone;
    logic [7:0] DmaSrc, DmaDst, DmaLen, DmaPattern;
    logic       MemWriteEn;
    logic [7:0] MemAddr, MemWData, MemRData;

    logic [7:0] mem    [256];
    logic [7:0] initmem[256];
    logic [7:0] refmem [256];

    typedef struct {
        bit         isWrite;
        logic [7:0] addr;
    } op_t;

    op_t        ops[$];
    bit         mFill;
    logic [7:0] mPat, mHold;
    int         mWait;
    bit         mDone;

    int checks = 0;
    int errors = 0;
    logic lastBusy, lastDone, lastNoGrant;

    dmem_dma_ctrl #(.W(8), .A(8), .MAXWAIT(MAXWAIT)) dut (
        .Clk(Clk), .Reset(Reset),
        .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuGrant(CpuGrant), .CpuRData(CpuRData),
        .DmaStart(DmaStart), .DmaFill(DmaFill), .DmaSrc(DmaSrc), .DmaDst(DmaDst),
        .DmaLen(DmaLen), .DmaPattern(DmaPattern),
        .DmaBusy(DmaBusy), .DmaDone(DmaDone),
        .MemWriteEn(MemWriteEn), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData)
    );

    // Free-running clock, period 10.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural memory: combinational read, write on the clock edge.
    assign MemRData = mem[MemAddr];
    always @(posedge Clk) begin
        if (MemWriteEn) mem[MemAddr] <= MemWData;
    end

    // One comparison. Every call counts, and every miss is reported.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit req, input bit we, input logic [7:0] addr,
                                 input logic [7:0] wdata);
        CpuReq   = req;
        CpuWe    = we;
        CpuAddr  = addr;
        CpuWData = wdata;
    endtask

    task automatic setDma(input bit start, input bit fillIn, input logic [7:0] srcIn,
                          input logic [7:0] dstIn, input logic [7:0] lenIn,
                          input logic [7:0] patIn);
        DmaStart   = start;
        DmaFill    = fillIn;
        DmaSrc     = srcIn;
        DmaDst     = dstIn;
        DmaLen     = lenIn;
        DmaPattern = patIn;
    endtask

    // One clock cycle. The outputs are checked against the model 2 time
    // units after the inputs are driven. At the rising edge the model then
    // advances by the same arbitration rules that the design must follow.
    task automatic tick();
        bit wants, forced, cpuWin, engWin, expWe, idleNow, nextDone;
        logic [7:0] expAddr, a;
        op_t op;
        #2;
        idleNow = (ops.size() == 0) && !mDone;
        wants   = (ops.size() > 0) && !Reset;
        forced  = wants && (mWait == MAXWAIT);
        cpuWin  = !forced && CpuReq;
        engWin  = forced || (wants && !CpuReq);
        expWe   = 1'b0;
        expAddr = CpuAddr;
        if (cpuWin) expWe = CpuWe;
        else if (engWin) begin
            expAddr = ops[0].addr;
            expWe   = ops[0].isWrite;
        end
        checkOutput("grant", {7'b0, CpuGrant}, {7'b0, cpuWin});
        checkOutput("busy", {7'b0, DmaBusy}, {7'b0, ops.size() > 0});
        checkOutput("done", {7'b0, DmaDone}, {7'b0, mDone});
        checkOutput("memwe", {7'b0, MemWriteEn}, {7'b0, expWe});
        if (cpuWin || engWin) checkOutput("memaddr", MemAddr, expAddr);
        if (cpuWin && !CpuWe) checkOutput("cpurdata", CpuRData, refmem[CpuAddr]);
        if (cpuWin && CpuWe) checkOutput("cpuwdata", MemWData, CpuWData);
        if (!cpuWin && engWin && ops[0].isWrite)
            checkOutput("engwdata", MemWData, mFill ? mPat : mHold);
        lastBusy    = DmaBusy;
        lastDone    = DmaDone;
        lastNoGrant = CpuReq && !CpuGrant;
        @(posedge Clk);
        if (cpuWin && CpuWe) refmem[CpuAddr] = CpuWData;
        if (Reset) begin
            ops.delete();
            mDone = 1'b0;
            mWait = 0;
        end else begin
            nextDone = 1'b0;
            if (engWin) begin
                op = ops.pop_front();
                if (!op.isWrite) mHold = refmem[op.addr];
                else refmem[op.addr] = mFill ? mPat : mHold;
                if (ops.size() == 0) nextDone = 1'b1;
                mWait = 0;
            end else if (wants) begin
                mWait = (mWait < MAXWAIT) ? mWait + 1 : MAXWAIT;
            end else begin
                mWait = 0;
            end
            if (idleNow && DmaStart) begin
                if (DmaLen == 8'd0) nextDone = 1'b1;
                else begin
                    mFill = DmaFill;
                    mPat  = DmaPattern;
                    for (int i = 0; i < int'(DmaLen); i++) begin
                        if (!DmaFill) begin
                            a = DmaSrc + 8'(i);
                            ops.push_back('{1'b0, a});
                        end
                        a = DmaDst + 8'(i);
                        ops.push_back('{1'b1, a});
                    end
                end
            end
            mDone = nextDone;
        end
        #1;
    endtask

    // Runs cycles until the model has no pending work or done pulse. It
    // reports how many cycles DmaBusy was high and how many cycles the
    // requesting CPU was denied. An expired budget counts as a failure.
    task automatic runUntilIdle(input int budget, output int busyCyc, output int noGrantCyc);
        int n;
        busyCyc    = 0;
        noGrantCyc = 0;
        n          = 0;
        DmaStart   = 1'b0;
        while ((ops.size() > 0 || mDone) && n < budget) begin
            tick();
            if (lastBusy === 1'b1) busyCyc++;
            if (lastNoGrant === 1'b1) noGrantCyc++;
            n++;
        end
        checkOutput("budget", {7'b0, n >= budget}, 8'd0);
    endtask

    initial begin
        int busyCyc, noGrantCyc;
        for (int i = 0; i < 256; i++) begin
            initmem[i] = 8'($urandom);
            mem[i]     = initmem[i];
        end
        initmem[8'h20] = 8'h11; initmem[8'h21] = 8'h22; initmem[8'h22] = 8'h33;
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33;
        for (int i = 0; i < 256; i++) refmem[i] = initmem[i];
        mWait = 0; mDone = 1'b0; mFill = 1'b0; mPat = 8'h00; mHold = 8'h00;

        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        setDma(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        tick();
        Reset = 1'b0;
        tick();

        $display("[TB] fill 0x10..0x13 with A5");
        setDma(1'b1, 1'b1, 8'h00, 8'h10, 8'd4, 8'hA5);
        tick();
        runUntilIdle(100, busyCyc, noGrantCyc);
        checkOutput("fillbusy", 8'(busyCyc), 8'd4);
        for (int i = 0; i < 4; i++) checkOutput("fillbyte", mem[8'h10 + i], 8'hA5);
        checkOutput("fillabove", mem[8'h14], initmem[8'h14]);

        $display("[TB] copy 0x20 -> 0x40 len 3");
        setDma(1'b1, 1'b0, 8'h20, 8'h40, 8'd3, 8'h00);
        tick();
        runUntilIdle(100, busyCyc, noGrantCyc);
        checkOutput("copybusy", 8'(busyCyc), 8'd6);
        checkOutput("copy0", mem[8'h40], 8'h11);
        checkOutput("copy1", mem[8'h41], 8'h22);
        checkOutput("copy2", mem[8'h42], 8'h33);

        $display("[TB] wrap fill at 0xFE");
        setDma(1'b1, 1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A);
        tick();
        runUntilIdle(100, busyCyc, noGrantCyc);
        checkOutput("wrapFE", mem[8'hFE], 8'h5A);
        checkOutput("wrapFF", mem[8'hFF], 8'h5A);
        checkOutput("wrap00", mem[8'h00], 8'h5A);
        checkOutput("wrap01", mem[8'h01], initmem[8'h01]);

        $display("[TB] starvation with CPU held requesting");
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
        setDma(1'b1, 1'b1, 8'h00, 8'h60, 8'd2, 8'h3C);
        tick();
        runUntilIdle(100, busyCyc, noGrantCyc);
        checkOutput("starvebusy", 8'(busyCyc), 8'd10);
        checkOutput("starvedeny", 8'(noGrantCyc), 8'd2);
        checkOutput("starve60", mem[8'h60], 8'h3C);
        checkOutput("starve61", mem[8'h61], 8'h3C);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        $display("[TB] CPU write races a copy read");
        setDma(1'b1, 1'b0, 8'h30, 8'h50, 8'd1, 8'h00);
        tick();
        DmaStart = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h30, 8'h77);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        runUntilIdle(100, busyCyc, noGrantCyc);
        checkOutput("coherent", mem[8'h50], 8'h77);
        applyStimulus(1'b1, 1'b0, 8'h50, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        $display("[TB] zero-length start");
        setDma(1'b1, 1'b1, 8'h00, 8'h08, 8'd0, 8'hEE);
        tick();
        DmaStart = 1'b0;
        tick();
        checkOutput("len0done", {7'b0, lastDone}, 8'd1);
        tick();
        checkOutput("len0mem", mem[8'h08], initmem[8'h08]);

        $display("[TB] start while busy is ignored");
        setDma(1'b1, 1'b1, 8'h00, 8'h70, 8'd3, 8'h11);
        tick();
        setDma(1'b1, 1'b1, 8'h00, 8'h80, 8'd2, 8'h22);
        tick();
        runUntilIdle(100, busyCyc, noGrantCyc);
        checkOutput("busy72", mem[8'h72], 8'h11);
        checkOutput("ignored80", mem[8'h80], initmem[8'h80]);

        $display("[TB] reset during a 5-byte copy");
        setDma(1'b1, 1'b0, 8'h90, 8'hA0, 8'd5, 8'h00);
        tick();
        DmaStart = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        checkOutput("rstbusy", {7'b0, lastBusy}, 8'd0);
        tick();
        checkOutput("rstdone", {7'b0, lastDone}, 8'd0);
        checkOutput("rstA0", mem[8'hA0], initmem[8'h90]);
        checkOutput("rstA1", mem[8'hA1], initmem[8'h91]);
        for (int i = 2; i < 5; i++) checkOutput("rstuntouched", mem[8'hA0 + i], initmem[8'hA0 + i]);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            Reset = ($urandom_range(0, 149) == 0);
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                          8'($urandom), 8'($urandom));
            setDma($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                   8'($urandom), 8'($urandom_range(0, 6)), 8'($urandom));
            tick();
        end
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        runUntilIdle(200, busyCyc, noGrantCyc);
        tick();
        for (int i = 0; i < 256; i++) checkOutput("memimage", mem[i], refmem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_dma_ctrl.md
Name: dmem_dma_ctrl

Overview:
- Owner of the single-port 8x256 data memory: arbitrates each cycle between the CPU load/store port and an internal block-copy/fill engine.
- Memory performs one read or one write per cycle, with combinational read and write on the Clk edge, so the engine sequences copies as a read cycle followed by a write cycle.
- The CPU has priority. A starvation counter guarantees the engine forward progress.

Parameters:
W, 8, data width in bits
A, 8, address width; memory depth 2**A
MAXWAIT, 4, consecutive engine-blocked cycles before the engine is forced one cycle (1..15)

Ports:
Clk  input  1  clock
Reset  input  1  synchronous, active-high reset
CpuReq  input  1  CPU requests memory access this cycle
CpuWe  input  1  CPU request is a write (valid with CpuReq)
CpuAddr  input  A  CPU address
CpuWData  input  W  CPU write data
CpuGrant  output  1  comb; CPU access performed this cycle (CPU must hold request while low)
CpuRData  output  W  comb; MemRData passthrough, valid when CpuGrant and !CpuWe
DmaStart  input  1  start command; sampled only when DmaBusy=0
DmaFill  input  1  1=fill Dst..Dst+Len-1 with DmaPattern; 0=copy Src->Dst
DmaSrc  input  A  copy source base
DmaDst  input  A  destination base
DmaLen  input  A  byte count; 0 = no-op
DmaPattern  input  W  fill byte
DmaBusy  output  1  registered; engine active
DmaDone  output  1  registered; one-cycle pulse at completion
MemWriteEn  output  1  comb; to memory WriteEn
MemAddr  output  A  comb; to memory DataAddress
MemWData  output  W  comb; to memory DataIn
MemRData  input  W  from memory DataOut

Behaviour:
- Reset:
  - state=IDLE; DmaBusy=0, DmaDone=0.
  - Wait counter, byte counter, address and holding registers cleared.
  - With CpuReq=0 during reset, MemWriteEn=0.
  - Reset mid-transfer aborts the transfer and raises no DmaDone. Bytes already written stay written.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - DmaStart=1 with Len!=0 latches Src, Dst, Len, Fill and Pattern.
  - Next state is WR if Fill, otherwise RD. DmaBusy=1 from the next cycle.
  - DmaStart=1 with Len=0 goes to DONE.
- Engine "wants" the memory in RD and WR.
- Arbitration, each cycle:
  - engine forced if waitcnt==MAXWAIT;
  - else the CPU wins if CpuReq;
  - else the engine wins if it wants.
- Forced cycle: CpuGrant=0. Otherwise CpuGrant=CpuReq.
- Wait counter:
  - increments when the engine wants and loses;
  - clears when the engine wins or is idle;
  - saturates at MAXWAIT.
- Memory drive:
  - CPU grant: MemAddr=CpuAddr, MemWriteEn=CpuWe, MemWData=CpuWData.
  - Engine RD: MemAddr=src, MemWriteEn=0; on the edge, MemRData is latched into hold and the state goes to WR.
  - Engine WR: MemAddr=dst, MemWriteEn=1, MemWData = Fill ? Pattern : hold.
  - After an engine WR, on the edge:
    - dst+=1 and src+=1 (mod 2**A, wrap 255->0);
    - count-=1;
    - if count becomes 0 go to DONE, else go to RD (copy) or stay in WR (fill).
  - No grant to anyone: MemWriteEn=0, MemAddr=CpuAddr, MemWData=CpuWData.
- Losing the arbitration leaves state, counters and hold unchanged.
- DONE: DmaDone=1 and DmaBusy=0 for exactly one cycle, then IDLE. DmaStart is ignored in DONE.
- DmaStart while DmaBusy=1 is ignored.
- Overlapping copy regions are processed in ascending address order. The result is defined only by that order.
- Throughput with no CPU traffic:
  - copy of N bytes: DmaBusy high 2N cycles;
  - fill of N bytes: DmaBusy high N cycles;
  - DmaDone in the following cycle.

Test Plan:
- Fill, idle CPU: DmaFill=1, Dst=0x10, Len=4, Pattern=0xA5 -> writes 0x10..0x13 on 4 consecutive cycles; DmaDone one cycle later; mem[0x14] unchanged.
- Copy, idle CPU: mem[0x20..0x22]=11,22,33; copy Src=0x20, Dst=0x40, Len=3 -> mem[0x40..0x42]=11,22,33; DmaBusy high 6 cycles.
- Wrap-around: fill Dst=0xFE, Len=3, Pattern=0x5A -> mem[0xFE], mem[0xFF] and mem[0x00] all equal 0x5A; mem[0x01] untouched.
- Starvation: CpuReq held 1 continuously during a fill of Len=2 with MAXWAIT=4 -> each engine write preceded by exactly 4 CPU grants, then one cycle with CpuGrant=0; fill completes.
- CPU coherence: CPU writes 0x77 to 0x30 while a copy reads 0x30 -> the copied byte equals the value present at the engine's RD cycle; CpuRData on a granted read equals mem[CpuAddr] the same cycle.
- Edge commands:
  - Len=0 start -> DmaDone pulse next cycle, no MemWriteEn.
  - DmaStart while busy -> ignored.
  - Reset during a copy at byte 2 of 5 -> DmaBusy=0, no DmaDone, bytes 3..5 not written.
